// File: rtl/cosim_pkg.sv
// Shared definitions for the co-simulation vector driver: default width,
// the LFSR/MISR feedback polynomial and the run-control state encoding.
package cosim_pkg;
  localparam int WIDTH_DEFAULT = 128;
  // x^128 + x^7 + x^2 + x + 1
  localparam logic [127:0] POLY = 128'h87;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
endpackage

// File: rtl/cosim_vec_driver_if.sv
// Control, stimulus and response bundle between the vector driver and its
// environment; master is the driver side.
interface cosim_vec_driver_if
  import cosim_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT,
  parameter int CNTW  = 16
);
  logic             start;
  logic             pause;
  logic [WIDTH-1:0] seed;
  logic [CNTW-1:0]  nvec;
  logic [WIDTH-1:0] stim_out;
  logic             stim_valid;
  logic [WIDTH-1:0] dut_out;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] signature;
  logic [CNTW-1:0]  count;

  modport master (
    input  start, pause, seed, nvec, dut_out,
    output stim_out, stim_valid, busy, done, signature, count
  );

  modport slave (
    output start, pause, seed, nvec, dut_out,
    input  stim_out, stim_valid, busy, done, signature, count
  );
endinterface

// File: rtl/cosim_lfsr_step.sv
// One Galois shift of x over POLY, xor-folded with din. Shared by the
// stimulus LFSR (din = 0) and the response MISR (din = DUT output).
module cosim_lfsr_step
  import cosim_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] y
);
  localparam logic [WIDTH-1:0] POLY_W = POLY[WIDTH-1:0];

  assign y = {x[WIDTH-2:0], 1'b0} ^ (x[WIDTH-1] ? POLY_W : '0) ^ din;
endmodule

// File: rtl/cosim_vec_driver.sv
// Applies nvec pseudo-random vectors to a combinational DUT and compacts
// the responses into a MISR signature; pause freezes the run.
module cosim_vec_driver
  import cosim_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT,
  parameter int CNTW  = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  cosim_vec_driver_if.master  bus
);
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] lfsr_q, lfsr_d;
  logic [WIDTH-1:0] misr_q, misr_d;
  logic [CNTW-1:0]  cnt_q, cnt_d;
  logic [CNTW-1:0]  nvec_q, nvec_d;

  logic [WIDTH-1:0] lfsr_nxt, misr_nxt;
  logic [CNTW-1:0]  cnt_inc;
  logic             vld;

  cosim_lfsr_step #(.WIDTH(WIDTH)) u_lfsr_step (
    .x   (lfsr_q),
    .din ('0),
    .y   (lfsr_nxt)
  );

  cosim_lfsr_step #(.WIDTH(WIDTH)) u_misr_step (
    .x   (misr_q),
    .din (bus.dut_out),
    .y   (misr_nxt)
  );

  assign vld     = (state_q == RUN) && !bus.pause;
  assign cnt_inc = cnt_q + CNTW'(1);

  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    misr_d  = misr_q;
    cnt_d   = cnt_q;
    nvec_d  = nvec_q;
    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          // An all-zero seed would lock the LFSR at zero
          lfsr_d  = (bus.seed == '0) ? ONE : bus.seed;
          misr_d  = '0;
          cnt_d   = '0;
          nvec_d  = bus.nvec;
          state_d = (bus.nvec != '0) ? RUN : DONE;
        end
      end
      RUN: begin
        if (vld) begin
          lfsr_d = lfsr_nxt;
          misr_d = misr_nxt;
          cnt_d  = cnt_inc;
          if (cnt_inc == nvec_q) state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      lfsr_q  <= ONE;
      misr_q  <= '0;
      cnt_q   <= '0;
      nvec_q  <= '0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      misr_q  <= misr_d;
      cnt_q   <= cnt_d;
      nvec_q  <= nvec_d;
    end
  end

  assign bus.stim_out   = lfsr_q;
  assign bus.stim_valid = vld;
  assign bus.busy       = (state_q == RUN);
  assign bus.done       = (state_q == DONE);
  assign bus.signature  = misr_q;
  assign bus.count      = cnt_q;
endmodule

// File: tb/tb_cosim_vec_driver.sv
// Bench for cosim_vec_driver with a bitwise-NOT DUT: directed table of runs,
// randomized runs against a sequence-level signature model, reset corner.
module tb_cosim_vec_driver;
  import cosim_pkg::*;

  localparam int W  = 128;
  localparam int CW = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cosim_vec_driver_if #(.WIDTH(W), .CNTW(CW)) bus ();
  assign bus.dut_out = ~bus.stim_out;

  cosim_vec_driver #(.WIDTH(W), .CNTW(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Multiply by x modulo the polynomial
  function automatic logic [W-1:0] mulx(input logic [W-1:0] v);
    logic [W-1:0] r;
    r = v << 1;
    if (v[W-1]) r = r ^ W'(128'h87);
    return r;
  endfunction

  // Signature expected after absorbing n responses of the NOT DUT
  function automatic logic [W-1:0] model_sig(input logic [W-1:0] s, input int n);
    logic [W-1:0] stim, sig;
    stim = (s == '0) ? W'(1) : s;
    sig  = '0;
    for (int k = 0; k < n; k++) begin
      sig  = mulx(sig) ^ ~stim;
      stim = mulx(stim);
    end
    return sig;
  endfunction

  // One run; p_after/p_len force a pause window, rnd adds random pauses
  task automatic run_case(input string nm, input logic [W-1:0] s, input logic [CW-1:0] n,
                          input int p_after, input int p_len, input bit rnd,
                          input logic [W-1:0] exp_sig);
    logic [W-1:0] es;
    int cyc, held, nvalid;
    bit win;
    bus.seed  = s;
    bus.nvec  = n;
    bus.pause = 1'b0;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    es = (s == '0) ? W'(1) : s;
    nvalid = 0; cyc = 0; held = 0;
    while (bus.done !== 1'b1 && cyc < 3000) begin
      win = (nvalid == p_after) && (held < p_len);
      if (win) bus.pause = 1'b1;
      else if (rnd) bus.pause = ($urandom_range(0, 3) == 0);
      else bus.pause = 1'b0;
      #1;
      if (win) begin
        chk({nm, " paused valid"}, W'(bus.stim_valid), '0);
        chk({nm, " paused count"}, W'(bus.count), W'(p_after));
        held++;
      end else begin
        chk({nm, " valid"}, W'(bus.stim_valid), W'(!bus.pause));
        if (bus.stim_valid) begin
          chk({nm, " stim"}, bus.stim_out, es);
          es = mulx(es);
          nvalid++;
        end
      end
      tick();
      cyc++;
    end
    bus.pause = 1'b0;
    chk({nm, " done"}, W'(bus.done), W'(1));
    chk({nm, " nvalid"}, W'(nvalid), W'(n));
    chk({nm, " sig"}, bus.signature, exp_sig);
    chk({nm, " count"}, W'(bus.count), W'(n));
    chk({nm, " busy"}, W'(bus.busy), '0);
    // DONE holds regardless of pause
    bus.pause = 1'b1;
    repeat (3) tick();
    bus.pause = 1'b0;
    chk({nm, " hold sig"}, bus.signature, exp_sig);
    chk({nm, " hold count"}, W'(bus.count), W'(n));
    chk({nm, " hold valid"}, W'(bus.stim_valid), '0);
  endtask

  typedef struct {
    string          nm;
    logic [W-1:0]   seed;
    logic [CW-1:0]  nvec;
    int             p_after;
    int             p_len;
    logic [W-1:0]   exp_sig;
  } vec_t;

  vec_t tbl[5];

  initial begin
    logic [W-1:0]  rs;
    logic [CW-1:0] rn;

    tbl[0] = '{"one",    W'(1), CW'(1), -1, 0, 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFE};
    tbl[1] = '{"two",    W'(1), CW'(2), -1, 0, W'(128'h86)};
    tbl[2] = '{"seed0",  W'(0), CW'(1), -1, 0, 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFE};
    tbl[3] = '{"nvec0",  W'(5), CW'(0), -1, 0, W'(0)};
    tbl[4] = '{"pause3", W'(1), CW'(2),  1, 3, W'(128'h86)};

    bus.start = 1'b0;
    bus.pause = 1'b0;
    bus.seed  = '0;
    bus.nvec  = '0;
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    chk("rst stim_out", bus.stim_out, W'(1));
    chk("rst valid", W'(bus.stim_valid), '0);
    chk("rst busy", W'(bus.busy), '0);
    chk("rst done", W'(bus.done), '0);
    chk("rst sig", bus.signature, '0);
    chk("rst count", W'(bus.count), '0);
    // pause outside RUN does nothing
    bus.pause = 1'b1;
    tick();
    bus.pause = 1'b0;
    chk("idle pause valid", W'(bus.stim_valid), '0);

    for (int i = 0; i < 5; i++)
      run_case(tbl[i].nm, tbl[i].seed, tbl[i].nvec, tbl[i].p_after, tbl[i].p_len, 1'b0,
               tbl[i].exp_sig);

    for (int i = 0; i < 8; i++) begin
      rs = {$urandom, $urandom, $urandom, $urandom};
      rn = CW'($urandom_range(1, 200));
      run_case($sformatf("rnd%0d", i), rs, rn, -1, 0, 1'b1, model_sig(rs, int'(rn)));
    end

    // Start ignored in RUN, then reset abandons the run
    rs = {$urandom, $urandom, $urandom, $urandom} | W'(1);
    bus.seed  = rs;
    bus.nvec  = CW'(100);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (5) tick();
    bus.seed  = W'(7);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("run start ignored count", W'(bus.count), W'(6));
    chk("run start ignored busy", W'(bus.busy), W'(1));
    repeat (4) tick();
    chk("mid count", W'(bus.count), W'(10));
    chk("mid sig", bus.signature, model_sig(rs, 10));
    rst_n = 1'b0;
    bus.start = 1'b1;
    tick();
    rst_n = 1'b1;
    bus.start = 1'b0;
    chk("mrst busy", W'(bus.busy), '0);
    chk("mrst done", W'(bus.done), '0);
    chk("mrst count", W'(bus.count), '0);
    chk("mrst sig", bus.signature, '0);
    chk("mrst stim", bus.stim_out, W'(1));
    tick();
    chk("mrst start ignored", W'(bus.busy), '0);

    // A fresh run after reset still works
    run_case("post rst", W'(1), CW'(2), -1, 0, 1'b0, W'(128'h86));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/cosim_vec_driver.md
COSIM_VEC_DRIVER -- requirements
Module: cosim_vec_driver

Interface
REQ-001 Parameter: WIDTH, default 128, width of stimulus and response vectors.
REQ-002 Parameter: CNTW, default 16, width of the vector counter.
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: rst_n  input  1  reset, synchronous, active-low.
REQ-005 Port: start  input  1  one-cycle pulse; begins a run from IDLE or DONE.
REQ-006 Port: pause  input  1  level; freezes the run while high.
REQ-007 Port: seed  input  WIDTH  LFSR seed, sampled on accepted start.
REQ-008 Port: nvec  input  CNTW  number of vectors to apply, sampled on accepted start.
REQ-009 Port: stim_out  output  WIDTH  registered stimulus, drives the combinational DUT input.
REQ-010 Port: stim_valid  output  1  high when the current stim_out is applied and its response is absorbed.
REQ-011 Port: dut_out  input  WIDTH  combinational DUT response to stim_out in the same cycle.
REQ-012 Port: busy  output  1  high in RUN.
REQ-013 Port: done  output  1  high in DONE.
REQ-014 Port: signature  output  WIDTH  MISR contents.
REQ-015 Port: count  output  CNTW  number of vectors absorbed so far.

Function
REQ-016 FSM states are IDLE, RUN and DONE.
REQ-017 IDLE + start: load lfsr = (seed==0 ? 1 : seed), misr=0, count=0, nvec_r=nvec; next state is RUN if nvec!=0, else DONE.
REQ-018 DONE + start behaves identically to IDLE + start.
REQ-019 start is ignored in RUN.
REQ-020 stim_valid = (state==RUN) && !pause; it is combinational from the state register and pause.
REQ-021 Each edge with stim_valid=1 updates three things: misr <= step(misr) ^ dut_out; lfsr <= step(lfsr); count <= count+1.
REQ-022 step(x) = {x[WIDTH-2:0],1'b0} ^ (x[WIDTH-1] ? POLY : 0), with POLY = 128'h87 (x^128+x^7+x^2+x+1).
REQ-023 stim_out = lfsr register, so the first applied vector equals the loaded seed.
REQ-024 RUN -> DONE on the edge where stim_valid=1 and count+1 == nvec_r; the last vector's response is absorbed on that edge.
REQ-025 pause high in RUN holds lfsr, misr, count and state unchanged; pause is ignored outside RUN.
REQ-026 In DONE, signature and count hold until the next accepted start.
REQ-027 count arithmetic is modulo 2^CNTW; nvec = 2^CNTW-1 is the largest run.
REQ-028 signature = misr register at all times, including during RUN.

Reset
REQ-029 On rst_n=0 at a clock edge: state=IDLE, lfsr=1, misr=0, count=0, nvec_r=0.
REQ-030 Reset values seen at the outputs: stim_out=1, stim_valid=0, busy=0, done=0, signature=0, count=0.
REQ-031 Reset mid-RUN abandons the run without absorbing the current vector; start in the reset cycle is ignored.

Structure
REQ-032 Shared package cosim_pkg holds WIDTH_DEFAULT=128, POLY=128'h87 and the state enum {IDLE, RUN, DONE}.
REQ-033 Sub-module cosim_lfsr_step (combinational, inputs x and din, output step(x)^din) is instantiated twice: LFSR with din=0, MISR with din=dut_out.
REQ-034 No other sub-modules.

Verification
(DUT = bitwise NOT of 128 bits in all scenarios)
REQ-035 seed=1, nvec=1, start -> one cycle with stim_out=1 and stim_valid=1; then done=1, count=1, signature=128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFE.
REQ-036 seed=1, nvec=2 -> stim_out sequence 1, 2; done after 2 valid cycles; signature=128'h86, count=2.
REQ-037 seed=0, nvec=1 -> stim_out=1 and signature identical to REQ-035; nvec=0 -> DONE the cycle after start, stim_valid never high, signature=0, count=0.
REQ-038 seed=1, nvec=2, pause high for 3 cycles after the first vector -> stim_valid low and count frozen at 1 for those 3 cycles; final signature=128'h86.
REQ-039 rst_n low for 1 cycle mid-run (nvec=100, after 10 vectors) -> next cycle state IDLE, count=0, signature=0, stim_out=1; start pulse in RUN before that reset is ignored.
